// File: rtl/branch_redirect_ctrl.sv
// Branch/jump resolution controller for the EX stage.
// Resolves BEQ/BNE/J/JR, registers the redirect target, sequences the PC
// load plus the IF/ID and ID/EX flush window, and keeps branch counters.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_branch_ne,
  input  logic                 ex_is_jump,
  input  logic                 ex_is_jr,
  input  logic                 ex_zero,
  input  logic [31:0]          ex_pc_plus4,
  input  logic [31:0]          ex_imm_sext,
  input  logic [25:0]          ex_jump_index,
  input  logic [31:0]          ex_rs_data,
  output logic                 pc_load,
  output logic [31:0]          pc_target,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 jr_misalign,
  output logic [CNT_WIDTH-1:0] taken_count,
  output logic [CNT_WIDTH-1:0] branch_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // Remaining FLUSH cycles after the redirect cycle; unused when the window is 1.
  localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES >= 2) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        pc_load_reg, flush_reg, jr_misalign_reg;
  logic [31:0] pc_target_reg;
  logic [CNT_WIDTH-1:0] taken_count_reg, branch_count_reg;

  logic        accept;
  logic        sel_jr, sel_jump, sel_branch;
  logic        branch_taken, taken;
  logic [31:0] target;
  logic        misalign_next;

  // Instruction decode with jr > jump > branch priority, and target selection.
  always_comb begin
    sel_jr       = ex_is_jr;
    sel_jump     = ~ex_is_jr & ex_is_jump;
    sel_branch   = ~ex_is_jr & ~ex_is_jump & ex_is_branch;
    branch_taken = sel_branch & (ex_zero ^ ex_branch_ne);
    taken        = sel_jr | sel_jump | branch_taken;
    accept       = ex_valid & ~stall & (state_reg == IDLE);
    if (sel_jr) begin
      target = {ex_rs_data[31:2], 2'b00};
    end else if (sel_jump) begin
      target = {ex_pc_plus4[31:28], ex_jump_index, 2'b00};
    end else begin
      target = ex_pc_plus4 + (ex_imm_sext << 2);
    end
    misalign_next = accept & sel_jr & (ex_rs_data[1:0] != 2'b00);
  end

  // Next-state logic for the redirect/flush sequencer.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept && taken) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (!stall) begin
          if (FLUSH_CYCLES <= 1) begin
            state_next = IDLE;
          end else begin
            state_next = FLUSH;
            cnt_next   = FLUSH_INIT;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (cnt_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, registered outputs and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= 4'd0;
      pc_load_reg      <= 1'b0;
      flush_reg        <= 1'b0;
      jr_misalign_reg  <= 1'b0;
      pc_target_reg    <= 32'd0;
      taken_count_reg  <= '0;
      branch_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      pc_load_reg     <= (state_next == REDIRECT);
      flush_reg       <= (state_next != IDLE);
      jr_misalign_reg <= misalign_next;
      if (accept && taken) begin
        pc_target_reg <= target;
      end
      if (accept && sel_branch) begin
        branch_count_reg <= branch_count_reg + 1'b1;
      end
      if (accept && taken) begin
        taken_count_reg <= taken_count_reg + 1'b1;
      end
    end
  end

  assign pc_load      = pc_load_reg;
  assign pc_target    = pc_target_reg;
  assign flush_if_id  = flush_reg;
  assign flush_id_ex  = flush_reg;
  assign jr_misalign  = jr_misalign_reg;
  assign taken_count  = taken_count_reg;
  assign branch_count = branch_count_reg;

endmodule
